dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/cpu_pkg.sv | 15 +
 rtl/timeout_ctr.sv | 37 +++
 rtl/dmem_ctrl.sv | 155 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the data-memory controller: FSM state encoding and
// the default bus-acknowledge timeout.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2,
      FAULT = 2'd3
   } dmem_state_e;

   localparam int TIMEOUT_DEF = 16;
   localparam int TCNT_W      = 8;

endpackage

// File: rtl/timeout_ctr.sv
// Counts BUSY cycles for the memory controller; expired is asserted during the
// last permitted BUSY cycle so the caller can still accept an ack in that cycle.
module timeout_ctr
   import cpu_pkg::*;
#(
   parameter int LIMIT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TCNT_W-1:0] cnt_q;
   logic [TCNT_W-1:0] cnt_d;

   assign expired = enable && (cnt_q == TCNT_W'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && !expired) begin
         cnt_d = cnt_q + TCNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns single-cycle core load/store requests into a
// req/ack bus transaction, stalling the core and reporting aborted accesses.
module dmem_ctrl
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int FCNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [31:0]       ALUResult,
   input  logic [31:0]       WriteData,
   output logic [31:0]       ReadData,
   output logic              Stall,
   output logic              MemFault,
   output logic [FCNT_W-1:0] FaultCount,
   output logic              bus_req,
   output logic              bus_we,
   output logic [31:0]       bus_addr,
   output logic [31:0]       bus_wdata,
   input  logic [31:0]       bus_rdata,
   input  logic              bus_ack,
   input  logic              bus_err
);

   function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] v);
      return (&v) ? v : v + FCNT_W'(1);
   endfunction

   dmem_state_e       state_q, state_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              req_q, req_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              fault_q, fault_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;
   logic              ready_q, ready_d;
   logic              ctr_clear;
   logic              ctr_expired;
   logic              access;

   assign access = MemRead | MemWrite;

   timeout_ctr #(
      .LIMIT(TIMEOUT)
   ) u_timeout_ctr (
      .clk    (clk),
      .reset  (reset),
      .clear  (ctr_clear),
      .enable (state_q == BUSY),
      .expired(ctr_expired)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      req_d     = 1'b0;
      rdata_d   = '0;
      fault_d   = 1'b0;
      fcnt_d    = fcnt_q;
      ready_d   = 1'b1;
      ctr_clear = 1'b0;
      Stall     = 1'b0;
      unique case (state_q)
         IDLE: begin
            Stall = access;
            // ready_q holds off the first request until the second edge after reset.
            if (access && ready_q) begin
               if (ALUResult[1:0] == 2'b00) begin
                  state_d   = BUSY;
                  addr_d    = ALUResult;
                  wdata_d   = WriteData;
                  we_d      = MemWrite;
                  req_d     = 1'b1;
                  ctr_clear = 1'b1;
               end else begin
                  state_d = FAULT;
                  fault_d = 1'b1;
                  fcnt_d  = sat_inc(fcnt_q);
               end
            end
         end
         BUSY: begin
            Stall = 1'b1;
            req_d = 1'b1;
            // An ack arriving in the expiry cycle takes precedence over the timeout.
            if (bus_ack) begin
               req_d = 1'b0;
               if (bus_err) begin
                  state_d = FAULT;
                  fault_d = 1'b1;
                  fcnt_d  = sat_inc(fcnt_q);
               end else begin
                  state_d = DONE;
                  if (!we_q) begin
                     rdata_d = bus_rdata;
                  end
               end
            end else if (ctr_expired) begin
               req_d   = 1'b0;
               state_d = FAULT;
               fault_d = 1'b1;
               fcnt_d  = sat_inc(fcnt_q);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         FAULT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         req_q   <= 1'b0;
         rdata_q <= '0;
         fault_q <= 1'b0;
         fcnt_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
         fcnt_q  <= fcnt_d;
         ready_q <= ready_d;
      end
   end

   assign ReadData   = rdata_q;
   assign MemFault   = fault_q;
   assign FaultCount = fcnt_q;
   assign bus_req    = req_q;
   assign bus_we     = we_q;
   assign bus_addr   = addr_q;
   assign bus_wdata  = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: stimulus pushes the expected completion of
// each access, a negedge monitor pops and compares when the core is released.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [31:0] ALUResult, WriteData;
   logic [31:0] ReadData;
   logic        Stall, MemFault;
   logic [7:0]  FaultCount;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic        bus_ack, bus_err;

   always #5 clk = ~clk;

   dmem_ctrl #(.TIMEOUT(16), .FCNT_W(8)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData),
      .Stall(Stall), .MemFault(MemFault), .FaultCount(FaultCount),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
      .bus_err(bus_err)
   );

   typedef struct {
      logic        fault;
      logic [31:0] rdata;
      logic [7:0]  fcnt;
      int          stall;
   } resp_t;

   resp_t      exp_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_fcnt = 8'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Completion monitor: a Stall 1->0 transition marks DONE or FAULT.
   int   run_len = 0;
   logic prev_stall = 1'b0;
   always @(negedge clk) begin
      resp_t e;
      if (!reset) begin
         prev_stall = 1'b0;
         run_len    = 0;
      end else begin
         if (prev_stall && !Stall) begin
            if (exp_q.size() == 0) begin
               check("unexpected_completion", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("resp_memfault", 32'(MemFault), 32'(e.fault));
               check("resp_readdata", ReadData, e.rdata);
               check("resp_faultcount", 32'(FaultCount), 32'(e.fcnt));
               check("resp_stall_cycles", 32'(run_len), 32'(e.stall));
            end
            run_len = 0;
         end
         if (Stall) run_len++;
         prev_stall = Stall;
      end
   end

   // One complete access from IDLE; ack_at = BUSY cycle of ack (0 = never).
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int ack_at, input logic err,
                         input logic [31:0] rdata, input int exp_req,
                         input logic exp_fault, input logic [31:0] exp_rdata);
      resp_t e;
      int    req_cycles;
      if (exp_fault && exp_fcnt != 8'hFF) exp_fcnt = exp_fcnt + 8'd1;
      e.fault = exp_fault;
      e.rdata = exp_rdata;
      e.fcnt  = exp_fcnt;
      e.stall = 1 + exp_req;
      exp_q.push_back(e);
      MemRead = rd; MemWrite = wr; ALUResult = addr; WriteData = wdata;
      tick();
      req_cycles = 0;
      for (int k = 1; k <= 40 && bus_req; k++) begin
         req_cycles++;
         if (k == 1) begin
            check("bus_we", 32'(bus_we), 32'(wr));
            check("bus_addr", bus_addr, addr);
            check("bus_wdata", bus_wdata, wdata);
         end else begin
            check("bus_addr_stable", bus_addr, addr);
         end
         if (k == ack_at) begin
            bus_ack = 1'b1; bus_err = err; bus_rdata = rdata;
         end
         tick();
         bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
      end
      check("bus_req_cycles", 32'(req_cycles), 32'(exp_req));
      MemRead = 1'b0; MemWrite = 1'b0;
      tick();
      check("readdata_after", ReadData, 32'h0);
      check("memfault_after", 32'(MemFault), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resp_t e;
      reset = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; ALUResult = '0; WriteData = '0;
      bus_rdata = '0; bus_ack = 1'b0; bus_err = 1'b0;
      tick(); tick();
      check("rst_bus_req", 32'(bus_req), 32'h0);
      check("rst_bus_we", 32'(bus_we), 32'h0);
      check("rst_bus_addr", bus_addr, 32'h0);
      check("rst_bus_wdata", bus_wdata, 32'h0);
      check("rst_readdata", ReadData, 32'h0);
      check("rst_memfault", 32'(MemFault), 32'h0);
      check("rst_faultcount", 32'(FaultCount), 32'h0);
      check("rst_stall", 32'(Stall), 32'h0);

      // First request right at reset release: bus_req only after the second edge.
      e.fault = 1'b0; e.rdata = 32'hA5A50000; e.fcnt = 8'd0; e.stall = 3;
      exp_q.push_back(e);
      reset = 1'b1; MemRead = 1'b1; ALUResult = 32'h10;
      tick();
      check("post_rst_edge1_req", 32'(bus_req), 32'h0);
      tick();
      check("post_rst_edge2_req", 32'(bus_req), 32'h1);
      bus_ack = 1'b1; bus_rdata = 32'hA5A50000;
      tick();
      bus_ack = 1'b0; bus_rdata = '0; MemRead = 1'b0;
      tick();
      check("post_rst_readdata_idle", ReadData, 32'h0);

      // rd wr addr wdata ack_at err rdata exp_req exp_fault exp_rdata
      access(1, 0, 32'h100, 32'h0,        2, 0, 32'hCAFE0001, 2,  0, 32'hCAFE0001);
      access(0, 1, 32'h204, 32'h12345678, 1, 0, 32'hDEADBEEF, 1,  0, 32'h0);
      access(1, 0, 32'h102, 32'h0,        1, 0, 32'h11111111, 0,  1, 32'h0);
      access(1, 0, 32'h300, 32'h0,        0, 0, 32'h0,        16, 1, 32'h0);
      access(1, 0, 32'h300, 32'h0,        16,0, 32'h0BADF00D, 16, 0, 32'h0BADF00D);
      access(1, 0, 32'h400, 32'h0,        3, 1, 32'h22222222, 3,  1, 32'h0);
      access(0, 1, 32'h201, 32'h55AA55AA, 1, 0, 32'h0,        0,  1, 32'h0);
      access(1, 1, 32'h508, 32'h87654321, 1, 0, 32'h33333333, 1,  0, 32'h0);
      check("faultcount_after_set", 32'(FaultCount), 32'd4);

      // Reset in the middle of a BUSY phase.
      MemRead = 1'b1; ALUResult = 32'h500;
      tick(); tick();
      check("busy_before_reset", 32'(bus_req), 32'h1);
      reset = 1'b0; MemRead = 1'b0;
      #1;
      check("reset_mid_busy_req", 32'(bus_req), 32'h0);
      check("reset_mid_busy_fault", 32'(MemFault), 32'h0);
      tick(); tick();
      reset = 1'b1;
      exp_fcnt = 8'd0;
      tick(); tick();
      check("after_release_fault", 32'(MemFault), 32'h0);
      check("after_release_count", 32'(FaultCount), 32'h0);
      check("after_release_stall", 32'(Stall), 32'h0);
      access(1, 0, 32'h600, 32'h0, 1, 0, 32'h76543210, 1, 0, 32'h76543210);

      // Saturation of the fault counter.
      for (int i = 0; i < 260; i++) begin
         access(1, 0, 32'h703, 32'h0, 1, 0, 32'h0, 0, 1, 32'h0);
      end
      check("faultcount_saturated", 32'(FaultCount), 32'hFF);

      tick(); tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
